// File: rtl/display_switcher.sv
// rtl/display_switcher.sv - registered display source selector with timed blanking and fault pattern
// Every source change is masked by BLANK_CYCLES of blank output; invalid selects drive all-segments-lit.
module display_switcher #(
  parameter int               N_SRC        = 5,
  parameter int               SEL_W        = 3,
  parameter int               DIGITS       = 4,
  parameter int               SEG_W        = 7,
  parameter int               LED_W        = 16,
  parameter int               BLANK_CYCLES = 1024,
  parameter logic [N_SRC-1:0] LED_EN       = '1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [N_SRC*DIGITS-1:0]   an_in_i,
  input  logic [N_SRC*SEG_W-1:0]    seg_in_i,
  input  logic [N_SRC*LED_W-1:0]    led_in_i,
  output logic [DIGITS-1:0]         an_o,
  output logic [SEG_W-1:0]          seg_o,
  output logic [LED_W-1:0]          led_o,
  output logic [SEL_W-1:0]          cur_sel_o,
  output logic                      busy_o,
  output logic                      fault_o
);

  localparam int               CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {S_SHOW, S_BLANK, S_FAULT} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;

  logic               sel_valid;
  logic [SEL_W-1:0]   load_sel;
  logic [DIGITS-1:0]  src_an;
  logic [SEG_W-1:0]   src_seg;
  logic [LED_W-1:0]   src_led;

  assign sel_valid = 32'(sel_i) < N_SRC;

  // In SHOW we refresh from the shown source; when leaving BLANK we load the target on the same edge.
  always_comb begin
    load_sel = (state_q == S_SHOW) ? cur_sel_q : target_q;
    src_an   = '1;
    src_seg  = '1;
    src_led  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (load_sel == SEL_W'(i)) begin
        src_an  = an_in_i[i*DIGITS +: DIGITS];
        src_seg = seg_in_i[i*SEG_W +: SEG_W];
        src_led = LED_EN[i] ? led_in_i[i*LED_W +: LED_W] : '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    an_d      = '1;
    seg_d     = '1;
    led_d     = '0;
    busy_d    = 1'b1;
    fault_d   = 1'b0;

    if (!sel_valid) begin
      state_d = S_FAULT;
      an_d    = '0;
      seg_d   = '0;
      busy_d  = 1'b0;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        S_SHOW: begin
          if (sel_i != cur_sel_q) begin
            state_d  = S_BLANK;
            target_d = sel_i;
            cnt_d    = CNT_LOAD;
          end else begin
            an_d   = src_an;
            seg_d  = src_seg;
            led_d  = src_led;
            busy_d = 1'b0;
          end
        end
        S_BLANK: begin
          if (sel_i != target_q) begin
            target_d = sel_i;
            cnt_d    = CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_d   = S_SHOW;
            cur_sel_d = target_q;
            an_d      = src_an;
            seg_d     = src_seg;
            led_d     = src_led;
            busy_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d  = S_BLANK;
          target_d = sel_i;
          cnt_d    = CNT_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_BLANK;
      target_q  <= '0;
      cur_sel_q <= '0;
      cnt_q     <= CNT_LOAD;
      an_q      <= '1;
      seg_q     <= '1;
      led_q     <= '0;
      busy_q    <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign an_o      = an_q;
  assign seg_o     = seg_q;
  assign led_o     = led_q;
  assign cur_sel_o = cur_sel_q;
  assign busy_o    = busy_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_display_switcher.sv
// tb/tb_display_switcher.sv - scoreboard bench for display_switcher against an edge-time reference model
module tb_display_switcher;

  localparam int            N  = 5;
  localparam int            SW = 3;
  localparam int            D  = 4;
  localparam int            SG = 7;
  localparam int            LW = 16;
  localparam int            BC = 4;
  localparam logic [N-1:0]  EN = 5'b11001;

  logic            clk = 1'b0;
  logic            reset;
  logic [SW-1:0]   sel;
  logic [N*D-1:0]  an_in;
  logic [N*SG-1:0] seg_in;
  logic [N*LW-1:0] led_in;
  logic [D-1:0]    an_o;
  logic [SG-1:0]   seg_o;
  logic [LW-1:0]   led_o;
  logic [SW-1:0]   cur_sel_o;
  logic            busy_o;
  logic            fault_o;

  always #5 clk = ~clk;

  display_switcher #(
    .N_SRC(N), .SEL_W(SW), .DIGITS(D), .SEG_W(SG), .LED_W(LW),
    .BLANK_CYCLES(BC), .LED_EN(EN)
  ) dut (
    .clk_i(clk), .reset_i(reset), .sel_i(sel),
    .an_in_i(an_in), .seg_in_i(seg_in), .led_in_i(led_in),
    .an_o(an_o), .seg_o(seg_o), .led_o(led_o),
    .cur_sel_o(cur_sel_o), .busy_o(busy_o), .fault_o(fault_o)
  );

  typedef struct packed {
    logic [D-1:0]  an;
    logic [SG-1:0] seg;
    logic [LW-1:0] led;
    logic [SW-1:0] cur;
    logic          busy;
    logic          fault;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference: tracks which source is visible and the edge number at which a pending source appears.
  int n         = 0;
  bit m_show    = 1'b0;
  bit m_fault   = 1'b0;
  int m_target  = 0;
  int m_cur     = 0;
  int m_show_at = 0;

  always @(posedge clk) begin
    exp_t e;
    int   s;
    s = int'(sel);
    n++;
    if (reset) begin
      m_show = 1'b0; m_fault = 1'b0; m_target = 0; m_cur = 0; m_show_at = n + BC;
    end else if (s >= N) begin
      m_fault = 1'b1; m_show = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b0; m_target = s; m_show_at = n + BC;
    end else if (m_show) begin
      if (s != m_cur) begin
        m_show = 1'b0; m_target = s; m_show_at = n + BC;
      end
    end else if (s != m_target) begin
      m_target = s; m_show_at = n + BC;
    end else if (n >= m_show_at) begin
      m_show = 1'b1; m_cur = m_target;
    end

    if (m_fault) begin
      e.an = '0; e.seg = '0; e.led = '0; e.busy = 1'b0; e.fault = 1'b1;
    end else if (m_show) begin
      e.an    = an_in[m_cur*D +: D];
      e.seg   = seg_in[m_cur*SG +: SG];
      e.led   = EN[m_cur] ? led_in[m_cur*LW +: LW] : '0;
      e.busy  = 1'b0;
      e.fault = 1'b0;
    end else begin
      e.an = '1; e.seg = '1; e.led = '0; e.busy = 1'b1; e.fault = 1'b0;
    end
    e.cur = SW'(m_cur);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    a = {an_o, seg_o, led_o, cur_sel_o, busy_o, fault_o};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0t: got output with no expected entry", $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t: got an=%b seg=%h led=%h cur=%0d busy=%b fault=%b, expected an=%b seg=%h led=%h cur=%0d busy=%b fault=%b",
                 vectors, $time, a.an, a.seg, a.led, a.cur, a.busy, a.fault,
                 e.an, e.seg, e.led, e.cur, e.busy, e.fault);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic randomize_sources();
    an_in  = (N*D)'($urandom);
    seg_in = (N*SG)'({$urandom, $urandom});
    led_in = (N*LW)'({$urandom, $urandom, $urandom});
  endtask

  initial begin
    reset = 1'b1;
    sel   = '0;
    randomize_sources();
    an_in[0 +: D]   = 4'b1110;
    seg_in[0 +: SG] = 7'h40;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    sel = 3'd1; cyc(7);
    sel = 3'd3; cyc(7);
    sel = 3'd2; cyc(2);
    sel = 3'd4; cyc(7);
    sel = 3'd6; cyc(2);
    sel = 3'd0; cyc(7);
    sel = 3'd1; cyc(6);
    led_in[LW +: LW] = ~led_in[LW +: LW]; cyc(1);
    an_in[D +: D] = 4'b0101; cyc(1);
    an_in[D +: D] = 4'b1011; cyc(2);
    sel = 3'd2; cyc(2);
    reset = 1'b1; sel = 3'd3; cyc(1);
    reset = 1'b0; cyc(7);
    repeat (300) begin
      randomize_sources();
      if ($urandom_range(0, 9) == 0) sel = SW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 79) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
